// File: rtl/draw_pkg.sv
// Shared types and widths for the draw sequencer slice.
// DRAW_TIMEOUT_EN (see draw_sequencer) enables the per-client watchdog.
package draw_pkg;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COLOR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } draw_state_t;

    // A single client still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_client_mux.sv
// Picks the selected drawer's pixel fields and strobes out of the packed client buses.
module draw_client_mux
    import draw_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [IDX_W-1:0]             sel,
    input  logic [NUM_CLIENTS*X_W-1:0]     ix_bus,
    input  logic [NUM_CLIENTS*Y_W-1:0]     iy_bus,
    input  logic [NUM_CLIENTS*COLOR_W-1:0] icolor_bus,
    input  logic [NUM_CLIENTS-1:0]         iwriteEn_bus,
    input  logic [NUM_CLIENTS-1:0]         idone_bus,
    output logic [X_W-1:0]                 sel_x,
    output logic [Y_W-1:0]                 sel_y,
    output logic [COLOR_W-1:0]             sel_color,
    output logic                           sel_write,
    output logic                           sel_done
);

    assign sel_x     = ix_bus[int'(sel) * X_W +: X_W];
    assign sel_y     = iy_bus[int'(sel) * Y_W +: Y_W];
    assign sel_color = icolor_bus[int'(sel) * COLOR_W +: COLOR_W];
    assign sel_write = iwriteEn_bus[sel];
    assign sel_done  = idone_bus[sel];

endmodule

// File: rtl/draw_sequencer.sv
// Runs enabled sprite drawers one at a time and forwards the active one's pixels to the VGA adapter.
// Optional watchdog per client: define DRAW_TIMEOUT_EN.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           iCLOCK_50,
    input  logic                           iresetn,
    input  logic                           istart,
    input  logic [NUM_CLIENTS-1:0]         ienable_mask,
    input  logic [NUM_CLIENTS*X_W-1:0]     ix_bus,
    input  logic [NUM_CLIENTS*Y_W-1:0]     iy_bus,
    input  logic [NUM_CLIENTS*COLOR_W-1:0] icolor_bus,
    input  logic [NUM_CLIENTS-1:0]         iwriteEn_bus,
    input  logic [NUM_CLIENTS-1:0]         idone_bus,
    output logic [NUM_CLIENTS-1:0]         odrawEn_bus,
    output logic [X_W-1:0]                 ox,
    output logic [Y_W-1:0]                 oy,
    output logic [COLOR_W-1:0]             ocolor,
    output logic                           oplot,
    output logic                           obusy,
    output logic                           oDoneSignal,
    output logic                           oerror
);

    localparam int IDX_W = idx_width(NUM_CLIENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    draw_state_t            state, state_next;
    logic [IDX_W-1:0]       idx, idx_next;
    logic [NUM_CLIENTS-1:0] mask, mask_next;

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_color;
    logic               sel_write;
    logic               sel_done;
    logic               timeout;
    logic               client_finished;

    draw_client_mux #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_mux (
        .sel          (idx),
        .ix_bus       (ix_bus),
        .iy_bus       (iy_bus),
        .icolor_bus   (icolor_bus),
        .iwriteEn_bus (iwriteEn_bus),
        .idone_bus    (idone_bus),
        .sel_x        (sel_x),
        .sel_y        (sel_y),
        .sel_color    (sel_color),
        .sel_write    (sel_write),
        .sel_done     (sel_done)
    );

    // A watchdog expiry advances exactly like a real done.
    assign client_finished = sel_done | timeout;
    assign obusy           = (state != ST_IDLE);

    always_ff @(posedge iCLOCK_50 or negedge iresetn) begin
        if (!iresetn) begin
            state <= ST_IDLE;
            idx   <= '0;
            mask  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            mask  <= mask_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        mask_next   = mask;
        odrawEn_bus = '0;
        case (state)
            ST_IDLE: begin
                if (istart) begin
                    mask_next  = ienable_mask;
                    idx_next   = '0;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mask[idx]) begin
                    state_next = ST_LAUNCH;
                end else if (idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx + IDX_ONE;
                end
            end
            ST_LAUNCH: begin
                odrawEn_bus[idx] = 1'b1;
                state_next       = ST_WAIT;
            end
            ST_WAIT: begin
                if (client_finished) begin
                    if (idx == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx + IDX_ONE;
                        state_next = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pixel fields are captured only while their client owns the port; the done pulse is registered too.
    always_ff @(posedge iCLOCK_50 or negedge iresetn) begin
        if (!iresetn) begin
            ox          <= '0;
            oy          <= '0;
            ocolor      <= '0;
            oplot       <= 1'b0;
            oDoneSignal <= 1'b0;
        end else begin
            oDoneSignal <= (state == ST_DONE);
            if (state == ST_WAIT) begin
                ox     <= sel_x;
                oy     <= sel_y;
                ocolor <= sel_color;
                oplot  <= sel_write;
            end else begin
                oplot  <= 1'b0;
            end
        end
    end

`ifdef DRAW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             error_q;

    assign timeout = (state == ST_WAIT) && !sel_done &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign oerror  = error_q;

    always_ff @(posedge iCLOCK_50 or negedge iresetn) begin
        if (!iresetn) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state == ST_LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign oerror             = 1'b0;
`endif

endmodule
